// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: two-road intersection controller with prescaled phase timing, sensor/walk demand and flash mode
module traffic_ctrl_param #(
    parameter int TICK_DIV   = 100000000,
    parameter int CNT_W      = 4,
    parameter int T_MAIN     = 12,
    parameter int T_MIN_MAIN = 6,
    parameter int T_SIDE     = 6,
    parameter int T_EXT      = 3,
    parameter int T_YEL      = 2,
    parameter int T_WALK     = 5,
    parameter int T_CLR      = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sensor,
    input  logic             i_walk,
    input  logic             i_flash,
    output logic [1:0]       o_main_light,
    output logic [1:0]       o_side_light,
    output logic             o_walk_light,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_remaining
);
    typedef enum logic [2:0] {
        INIT  = 3'd0,
        G_R   = 3'd1,
        Y_R   = 3'd2,
        R_G   = 3'd3,
        R_Y   = 3'd4,
        WALK  = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]    r_pre;
    state_t           r_state, w_state_nx, w_seq_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_dur, w_dur_nx, r_rem;
    logic             r_side_req, r_walk_req, r_ext_used, r_fph;
    logic             w_side_req_nx, w_walk_req_nx, w_ext_nx, w_fph_nx;
    logic             w_side_eff, w_walk_eff, w_tick;
    logic [1:0]       r_main, r_side;
    logic             r_walk_light;

    function automatic logic [CNT_W-1:0] f_dur(input state_t s, input logic sr, input logic ex);
        return (s == INIT)  ? CNT_W'(T_CLR) :
               (s == G_R)   ? (sr ? CNT_W'(T_MIN_MAIN) : CNT_W'(T_MAIN)) :
               (s == R_G)   ? (ex ? CNT_W'(T_SIDE + T_EXT) : CNT_W'(T_SIDE)) :
               (s == WALK)  ? CNT_W'(T_WALK) :
               (s == FLASH) ? '0 : CNT_W'(T_YEL);
    endfunction

    assign w_tick = (r_pre == PW'(TICK_DIV - 1));

    // demand seen on this very clk already counts, so a late sensor ends main green on the same tick
    always_comb begin
        w_side_eff    = r_side_req | (r_state == G_R && i_sensor);
        w_walk_eff    = r_walk_req | (r_state != WALK && i_walk);
        w_dur         = f_dur(r_state, w_side_eff, r_ext_used);
        w_seq_nx      = (r_state == INIT) ? G_R :
                        (r_state == G_R)  ? Y_R :
                        (r_state == Y_R)  ? (w_walk_eff ? WALK : R_G) :
                        (r_state == R_G)  ? R_Y :
                        (r_state == R_Y)  ? G_R : R_G;
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_side_req_nx = w_side_eff;
        w_walk_req_nx = w_walk_eff;
        w_ext_nx      = r_ext_used;
        w_fph_nx      = r_fph;
        if (w_tick) begin
            if (i_flash) begin
                w_state_nx = FLASH;
                w_cnt_nx   = '0;
                w_fph_nx   = (r_state == FLASH) & ~r_fph;
                if (r_state != FLASH) begin
                    w_side_req_nx = 1'b0;
                    w_walk_req_nx = 1'b0;
                end
            end else if (r_state == FLASH) begin
                w_state_nx = INIT;
                w_cnt_nx   = '0;
            end else if (r_state == R_G && !r_ext_used && i_sensor && r_cnt == CNT_W'(T_SIDE - 1)) begin
                w_ext_nx = 1'b1;
                w_cnt_nx = r_cnt + 1'b1;
            end else if (r_cnt >= w_dur - 1'b1) begin
                w_state_nx = w_seq_nx;
                w_cnt_nx   = '0;
                if (w_seq_nx == WALK) w_walk_req_nx = 1'b0;
                if (w_seq_nx == R_G) begin
                    w_side_req_nx = 1'b0;
                    w_ext_nx      = 1'b0;
                end
            end else begin
                w_cnt_nx = r_cnt + 1'b1;
            end
        end
        w_dur_nx = f_dur(w_state_nx, w_side_req_nx, w_ext_nx);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pre        <= '0;
            r_state      <= INIT;
            r_cnt        <= '0;
            r_side_req   <= 1'b0;
            r_walk_req   <= 1'b0;
            r_ext_used   <= 1'b0;
            r_fph        <= 1'b0;
            r_main       <= 2'd3;
            r_side       <= 2'd3;
            r_walk_light <= 1'b0;
            r_rem        <= CNT_W'(T_CLR);
        end else begin
            r_pre        <= w_tick ? '0 : r_pre + 1'b1;
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_side_req   <= w_side_req_nx;
            r_walk_req   <= w_walk_req_nx;
            r_ext_used   <= w_ext_nx;
            r_fph        <= w_fph_nx;
            r_main       <= (w_state_nx == FLASH) ? (w_fph_nx ? 2'd0 : 2'd2) :
                            (w_state_nx == G_R)   ? 2'd1 :
                            (w_state_nx == Y_R)   ? 2'd2 : 2'd3;
            r_side       <= (w_state_nx == FLASH) ? (w_fph_nx ? 2'd0 : 2'd3) :
                            (w_state_nx == R_G)   ? 2'd1 :
                            (w_state_nx == R_Y)   ? 2'd2 : 2'd3;
            r_walk_light <= (w_state_nx == WALK);
            r_rem        <= (w_state_nx == FLASH)  ? '0 :
                            (w_cnt_nx >= w_dur_nx) ? CNT_W'(1) : w_dur_nx - w_cnt_nx;
        end
    end

    assign o_main_light = r_main;
    assign o_side_light = r_side;
    assign o_walk_light = r_walk_light;
    assign o_state      = r_state;
    assign o_remaining  = r_rem;
endmodule
